// File: rtl/camera_pixel_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : camera_pixel_packer_pkg
// Description : Shared camera definitions: frame geometry defaults, RGB565
//               field layout, byte-pairing FSM states and a packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package camera_pixel_packer_pkg;

  // Default camera geometry (QVGA)
  localparam int c_H_PIXELS_DEFAULT = 320;
  localparam int c_V_LINES_DEFAULT  = 240;

  // RGB565 field widths
  localparam int c_R_W   = 5;
  localparam int c_G_W   = 6;
  localparam int c_B_W   = 5;
  localparam int c_PIX_W = c_R_W + c_G_W + c_B_W;

  // Byte-pairing FSM: the camera sends each pixel as high byte then low byte
  typedef enum logic [0:0] {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } byte_state_e;

  typedef struct packed {
    logic [c_R_W-1:0] r;
    logic [c_G_W-1:0] g;
    logic [c_B_W-1:0] b;
  } rgb565_t;

  // The camera already emits RGB565 MSB-first, so packing is a concatenation
  function automatic rgb565_t pack_rgb565(input logic [7:0] hi_byte,
                                          input logic [7:0] lo_byte);
    return rgb565_t'({hi_byte, lo_byte});
  endfunction

endpackage
`default_nettype wire

// File: rtl/camera_pixel_packer_fb_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fb_addr_gen
// Description : Combinational frame-buffer address: vcount*H_PIXELS + hcount.
//               Shared by the camera write side and the display read side.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_addr_gen
  import camera_pixel_packer_pkg::*;
#(
  parameter int H_PIXELS = c_H_PIXELS_DEFAULT
) (
  input  logic [8:0]  hcount_i,
  input  logic [7:0]  vcount_i,
  output logic [16:0] addr_o
);

  localparam logic [16:0] c_ROW_STRIDE = 17'(H_PIXELS);

  logic [16:0] w_row_base;

  // Row base plus column offset; no registers so callers see zero latency
  always_comb begin
    w_row_base = 17'(vcount_i) * c_ROW_STRIDE;
    addr_o     = w_row_base + 17'(hcount_i);
  end

endmodule
`default_nettype wire

// File: rtl/camera_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : camera_pixel_packer
// Description : Pairs camera bytes (sampled on rising pclk, already in the
//               clk_in domain) into RGB565 pixels with column/row counters,
//               frame-buffer address and a frame-done strobe on VSYNC.
// Revision    : 1.0 - initial release
// ============================================================================
module camera_pixel_packer
  import camera_pixel_packer_pkg::*;
#(
  parameter int H_PIXELS = c_H_PIXELS_DEFAULT,
  parameter int V_LINES  = c_V_LINES_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        camera_pclk_in,
  input  logic        camera_hs_in,
  input  logic        camera_vs_in,
  input  logic [7:0]  camera_data_in,
  output logic        pixel_valid_out,
  output logic [15:0] pixel_data_out,
  output logic [8:0]  pixel_hcount_out,
  output logic [7:0]  pixel_vcount_out,
  output logic [16:0] pixel_addr_out,
  output logic        frame_done_out
);

  localparam logic [8:0] c_H_LIMIT = 9'(H_PIXELS);
  localparam logic [7:0] c_V_LIMIT = 8'(V_LINES);

  // Sample-event detection and sync history
  logic pclk_q;
  logic hs_prev_q;
  logic vs_prev_q;
  logic w_sample;
  logic w_vs_evt;
  logic w_pix_byte;
  logic w_line_end;
  logic w_pix_done;
  logic w_in_frame;

  // FSM and counters
  byte_state_e state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [8:0]  col_q, col_d;
  logic [7:0]  row_q, row_d;
  logic [16:0] w_addr;

  // Registered outputs
  logic        valid_q, valid_d;
  logic [15:0] data_q, data_d;
  logic [8:0]  hcount_q, hcount_d;
  logic [7:0]  vcount_q, vcount_d;
  logic [16:0] addr_q, addr_d;
  logic        fdone_q, fdone_d;

  // Classify the current cycle; VSYNC overrides HREF
  always_comb begin
    w_sample   = camera_pclk_in & ~pclk_q;
    w_vs_evt   = w_sample & camera_vs_in;
    w_pix_byte = w_sample & ~camera_vs_in & camera_hs_in;
    w_line_end = w_sample & ~camera_vs_in & ~camera_hs_in & hs_prev_q;
    w_pix_done = w_pix_byte & (state_q == ST_SECOND);
    w_in_frame = (col_q < c_H_LIMIT) && (row_q < c_V_LIMIT);
  end

  // Address of the pixel being completed, taken from the live counters
  fb_addr_gen #(
    .H_PIXELS (H_PIXELS)
  ) u_fb_addr_gen (
    .hcount_i (col_q),
    .vcount_i (row_q),
    .addr_o   (w_addr)
  );

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_FIRST;
    else        state_q <= state_d;
  end

  // FSM next state: alternate on line bytes, realign on line end or VSYNC
  always_comb begin
    state_d = state_q;
    if (w_vs_evt || w_line_end) begin
      state_d = ST_FIRST;
    end else if (w_pix_byte) begin
      state_d = (state_q == ST_FIRST) ? ST_SECOND : ST_FIRST;
    end
  end

  // FSM outputs: high-byte capture, counters and pixel emission
  always_comb begin
    hi_d     = hi_q;
    col_d    = col_q;
    row_d    = row_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    addr_d   = addr_q;
    fdone_d  = 1'b0;

    if (w_vs_evt) begin
      col_d   = '0;
      row_d   = '0;
      fdone_d = ~vs_prev_q;
    end else if (w_line_end) begin
      col_d = '0;
      if (row_q < c_V_LIMIT) row_d = row_q + 8'd1;
    end else if (w_pix_byte) begin
      if (state_q == ST_FIRST) begin
        hi_d = camera_data_in;
      end else begin
        if (col_q < c_H_LIMIT) col_d = col_q + 9'd1;
        // Pixels beyond the visible window are counted but not emitted
        if (w_in_frame) begin
          valid_d  = 1'b1;
          data_d   = pack_rgb565(hi_q, camera_data_in);
          hcount_d = col_q;
          vcount_d = row_q;
          addr_d   = w_addr;
        end
      end
    end
  end

  // Datapath and history registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pclk_q    <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      hi_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      addr_q    <= '0;
      fdone_q   <= 1'b0;
    end else begin
      pclk_q <= camera_pclk_in;
      if (w_sample) begin
        hs_prev_q <= camera_hs_in;
        vs_prev_q <= camera_vs_in;
      end
      hi_q     <= hi_d;
      col_q    <= col_d;
      row_q    <= row_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      addr_q   <= addr_d;
      fdone_q  <= fdone_d;
    end
  end

  assign pixel_valid_out  = valid_q;
  assign pixel_data_out   = data_q;
  assign pixel_hcount_out = hcount_q;
  assign pixel_vcount_out = vcount_q;
  assign pixel_addr_out   = addr_q;
  assign frame_done_out   = fdone_q;

endmodule
`default_nettype wire

// File: tb/tb_camera_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_pixel_packer
// Description : Self-checking bench for camera_pixel_packer with a byte-count
//               based reference model and randomized camera traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_pixel_packer;

  localparam int H = 320;
  localparam int V = 240;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        pclk = 1'b0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        pixel_valid_out;
  logic [15:0] pixel_data_out;
  logic [8:0]  pixel_hcount_out;
  logic [7:0]  pixel_vcount_out;
  logic [16:0] pixel_addr_out;
  logic        frame_done_out;

  camera_pixel_packer #(
    .H_PIXELS (H),
    .V_LINES  (V)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .camera_pclk_in   (pclk),
    .camera_hs_in     (hs),
    .camera_vs_in     (vs),
    .camera_data_in   (data),
    .pixel_valid_out  (pixel_valid_out),
    .pixel_data_out   (pixel_data_out),
    .pixel_hcount_out (pixel_hcount_out),
    .pixel_vcount_out (pixel_vcount_out),
    .pixel_addr_out   (pixel_addr_out),
    .frame_done_out   (frame_done_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: a line is a byte sequence; byte 2k+1 completes pixel k.
  // Row is the number of line ends since VSYNC, capped at V.
  int          m_idx;
  int          m_row;
  bit          m_prev_hs;
  bit          m_prev_vs;
  logic [7:0]  m_hi;
  logic [15:0] l_data;
  int          l_h, l_v, l_a;

  task automatic model_reset();
    m_idx = 0; m_row = 0; m_prev_hs = 0; m_prev_vs = 0; m_hi = 8'h00;
    l_data = 16'h0000; l_h = 0; l_v = 0; l_a = 0;
  endtask

  task automatic model_sample(input bit s_hs, input bit s_vs, input logic [7:0] b,
                              output bit e_valid, output bit e_fd);
    int k;
    e_valid = 0;
    e_fd    = 0;
    if (s_vs) begin
      e_fd  = !m_prev_vs;
      m_idx = 0;
      m_row = 0;
    end else if (s_hs) begin
      if (m_idx % 2 == 0) begin
        m_hi = b;
      end else begin
        k = m_idx / 2;
        if (k < H && m_row < V) begin
          e_valid = 1;
          l_data  = {m_hi, b};
          l_h     = k;
          l_v     = m_row;
          l_a     = m_row * H + k;
        end
      end
      m_idx++;
    end else if (m_prev_hs) begin
      m_idx = 0;
      if (m_row < V) m_row++;
    end
    m_prev_hs = s_hs;
    m_prev_vs = s_vs;
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, "_data"},   pixel_data_out,   l_data);
    chk({tag, "_hcount"}, pixel_hcount_out, l_h);
    chk({tag, "_vcount"}, pixel_vcount_out, l_v);
    chk({tag, "_addr"},   pixel_addr_out,   l_a);
  endtask

  task automatic idle_chk();
    chk("idle_valid", pixel_valid_out, 0);
    chk("idle_fdone", frame_done_out, 0);
    chk_fields("hold");
  endtask

  // One camera byte: pclk low for a cycle, then high for 'hold' cycles
  task automatic step(input bit s_hs, input bit s_vs, input logic [7:0] b, input int hold = 1);
    bit ev, ef;
    @(negedge clk_in);
    idle_chk();
    pclk = 1'b0; hs = s_hs; vs = s_vs; data = b;
    @(negedge clk_in);
    idle_chk();
    pclk = 1'b1;
    @(negedge clk_in);
    model_sample(s_hs, s_vs, b, ev, ef);
    chk("strobe", pixel_valid_out, ev);
    chk("frame_done", frame_done_out, ef);
    chk_fields("pix");
    for (int i = 1; i < hold; i++) begin
      @(negedge clk_in);
      idle_chk();
    end
  endtask

  task automatic line(input int nbytes);
    for (int i = 0; i < nbytes; i++) step(1'b1, 1'b0, 8'($urandom));
    step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic new_frame();
    step(1'b0, 1'b1, 8'($urandom));
    step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1; pclk = 1'b0; hs = 1'b0; vs = 1'b0; data = 8'($urandom);
    repeat (2) @(negedge clk_in);
    chk("rst_valid",  pixel_valid_out,  0);
    chk("rst_data",   pixel_data_out,   0);
    chk("rst_hcount", pixel_hcount_out, 0);
    chk("rst_vcount", pixel_vcount_out, 0);
    chk("rst_addr",   pixel_addr_out,   0);
    chk("rst_fdone",  frame_done_out,   0);
    rst_in = 1'b0;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    do_reset();

    // Basic pair after reset
    step(1'b1, 1'b0, 8'hA9);
    step(1'b1, 1'b0, 8'h91);
    chk("pair_data",   pixel_data_out,   16'hA991);
    chk("pair_hcount", pixel_hcount_out, 0);
    chk("pair_addr",   pixel_addr_out,   0);
    step(1'b0, 1'b0, 8'h00);

    // Full line then the start of the next one
    new_frame();
    line(640);
    chk("line_lastcol", pixel_hcount_out, 319);
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    chk("line2_addr",   pixel_addr_out,   320);
    chk("line2_vcount", pixel_vcount_out, 1);
    for (int i = 0; i < 638; i++) step(1'b1, 1'b0, 8'($urandom));
    step(1'b0, 1'b0, 8'h00);

    // Odd-length overlong line, then a short line realigned to FIRST
    line(641);
    line(10);
    chk("after_odd_hcount", pixel_hcount_out, 4);

    // VSYNC mid-line, held for two samples; then first pixel at origin
    for (int i = 0; i < 101; i++) step(1'b1, 1'b0, 8'($urandom));
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h5A);
    step(1'b1, 1'b0, 8'hC3);
    chk("vs_addr", pixel_addr_out, 0);
    chk("vs_data", pixel_data_out, 16'h5AC3);

    // pclk held high counts once; toggling with hs low emits nothing
    step(1'b1, 1'b0, 8'hDE, 5);
    step(1'b1, 1'b0, 8'hAD);
    chk("hold_pclk_data", pixel_data_out, 16'hDEAD);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'($urandom));

    // Reset in the middle of a pair
    step(1'b0, 1'b0, 8'h00);
    new_frame();
    step(1'b1, 1'b0, 8'h77);
    do_reset();
    step(1'b1, 1'b0, 8'h12);
    step(1'b1, 1'b0, 8'h34);
    chk("rst_mid_data", pixel_data_out, 16'h1234);
    step(1'b0, 1'b0, 8'h00);

    // Row saturation: more than V short lines
    new_frame();
    for (int l = 0; l < V + 5; l++) line(2);
    chk("row_sat_vcount", pixel_vcount_out, V - 1);

    // Randomized frames
    for (int f = 0; f < 3; f++) begin
      new_frame();
      for (int l = 0; l < 3; l++) begin
        line(int'($urandom_range(0, 700)));
        for (int g = 0; g < int'($urandom_range(0, 3)); g++)
          step(1'b0, 1'b0, 8'($urandom));
      end
    end

    @(negedge clk_in);
    idle_chk();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
